alu_exec_sequencer: RTL and testbench
=====================================

// Module: alu_exec_sequencer
// PURPOSE
//  Multicycle control FSM that sequences the 16-bit RISC ALU and data memory for one instruction at a time.
//  It accepts a fetched instruction and drives the ALU start levels (isALUOP / isLoadStore).
//  It waits on the ALU flags and the memory handshake, then issues write-back, PC select and the fetchNextInst pulse.
//  It sits between the fetch stage and the ALU/data-memory pair, and adds a watchdog plus a retired-instruction count.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles waited in EXEC or MEM before aborting (>=2)
//  CNT_W           16  width of instr_count
// PORTS
//  clk            in   1      system clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  instr_valid    in   1      fetch has an instruction on instr
//  instr          in   16     [15:12] opcode, [11:9] rd, [5:0] offset
//  instr_ready    out  1      sequencer can accept an instruction
//  opcode         out  4      latched opcode to ALU
//  offset         out  6      latched offset to ALU
//  isALUOP        out  1      ALU start level, opcodes 2..12
//  isLoadStore    out  1      ALU start level, opcodes 0..1
//  isALUFinished  in   1      ALU done flag
//  execute_branch in   1      ALU branch-taken flag
//  jump_flag      in   1      ALU jump flag
//  memRead        out  1      data memory read request (load)
//  memWrite       out  1      data memory write request (store)
//  mem_done       in   1      data memory access complete
//  reg_write      out  1      register file write strobe
//  rd_addr        out  3      write-back register index
//  pc_sel         out  2      00 pc+1, 01 branch target, 10 jump target; valid with fetchNextInst
//  fetchNextInst  out  1      one-cycle pulse that clears ALU flags and advances fetch
//  busy           out  1      high in every state except IDLE
//  illegal_op     out  1      one-cycle pulse, opcode 13..15
//  timeout_err    out  1      sticky; cleared only by rst_n
//  instr_count    out  CNT_W  retired instructions, wraps at 2^CNT_W
// BEHAVIOUR
//  Outputs and FSM:
//  - All outputs are registered Moore outputs. rst_n low clears all outputs and the FSM to IDLE immediately.
//    This includes dropping isALUOP, isLoadStore, memRead and memWrite mid-operation.
//  - instr_ready rises on the first clk edge after rst_n is released.
//  - States: IDLE, DECODE, EXEC, MEM, WB, RELEASE.
//  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr into IR and go to DECODE. instr is ignored otherwise.
//  - DECODE: if opcode>=13, pulse illegal_op, set pc_sel=00 and go to RELEASE (not counted as retired).
//    Otherwise, stall while any of isALUFinished/execute_branch/jump_flag is still high.
//    Then go to EXEC and clear the watchdog counter.
//  EXEC and MEM:
//  - EXEC: hold isLoadStore (op 0,1) or isALUOP (op 2..12) high for the whole state. The watchdog increments every cycle.
//    Exit priority when flags are sampled together: jump_flag > execute_branch > isALUFinished.
//  - EXEC exits:
//    - jump_flag: pc_sel=10, go to RELEASE.
//    - execute_branch: pc_sel=01, go to RELEASE.
//    - isALUFinished with op 0/1: go to MEM.
//    - isALUFinished with op 2..9: go to WB.
//    - isALUFinished with op 10/11: pc_sel=00, go to RELEASE.
//    - The start level drops on the exit edge.
//  - MEM: memRead (op 0) or memWrite (op 1) is held high until mem_done is sampled; the watchdog is cleared on entry.
//    Load then goes to WB; store goes to RELEASE with pc_sel=00.
//  - Watchdog: if the counter reaches TIMEOUT_CYCLES-1 in EXEC or MEM without an exit condition:
//    set timeout_err, drop the start/request, set pc_sel=00 and go to RELEASE.
//    An exit condition in that same cycle wins over the timeout.
//  WB and RELEASE:
//  - WB: reg_write=1 for exactly one cycle with rd_addr=IR[11:9], then go to RELEASE with pc_sel=00.
//  - RELEASE: fetchNextInst=1 for exactly one cycle; pc_sel holds its value. Then go to IDLE.
//    instr_count increments (wrapping) unless the instruction was illegal or timed out.
//  Timing and boundaries:
//  - Minimum latency, ALU op with a 1-cycle ALU: handshake at edge T0, DECODE T1, isALUOP high T2, WB T3,
//    fetchNextInst T4, instr_ready T5.
//  - Back-to-back: a new instruction is accepted no earlier than the cycle after RELEASE. No overlap exists.
//  - mem_done or ALU flags arriving outside EXEC/MEM are ignored.
// TESTING
//  1. Reset, then ADD (instr=16'h2A00), ALU finishes 1 cycle after isALUOP -> isALUOP high 1 cycle;
//     reg_write with rd_addr=5 at T3; fetchNextInst at T4 with pc_sel=00; instr_count=1.
//  2. LOAD (16'h0C05), mem_done 3 cycles after memRead -> isLoadStore, then memRead 3 cycles, reg_write rd=6,
//     fetchNextInst, pc_sel=00.
//  3. BEQZ (op 10) with execute_branch=1 -> no reg_write; fetchNextInst with pc_sel=01.
//     JUMP (op 12) with jump_flag=1 -> pc_sel=10.
//  4. ALU never responds, TIMEOUT_CYCLES=8 -> isALUOP drops after 8 cycles; timeout_err=1 sticky;
//     fetchNextInst pulse; instr_count unchanged.
//  5. instr=16'hE000 -> illegal_op one-cycle pulse, no isALUOP; fetchNextInst with pc_sel=00; count unchanged.
//  6. rst_n low while memWrite is high -> all outputs 0 asynchronously; after release, instr_ready=1 on the first edge;
//     timeout_err=0, instr_count=0.

Source files
------------

// File: rtl/alu_exec_sequencer.sv
// Multicycle sequencer for the 16-bit RISC ALU and data memory, one instruction at a time.
// Outputs are registered from the next-state decode; a watchdog aborts stuck EXEC/MEM phases.
module alu_exec_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [3:0]       opcode,
  output logic [5:0]       offset,
  output logic             isALUOP,
  output logic             isLoadStore,
  input  logic             isALUFinished,
  input  logic             execute_branch,
  input  logic             jump_flag,
  output logic             memRead,
  output logic             memWrite,
  input  logic             mem_done,
  output logic             reg_write,
  output logic [2:0]       rd_addr,
  output logic [1:0]       pc_sel,
  output logic             fetchNextInst,
  output logic             busy,
  output logic             illegal_op,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_d;
  logic [5:0]      off_d;
  logic [2:0]      rd_d;
  logic [1:0]      pc_sel_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            no_retire_q, no_retire_d;
  logic            illegal_d, timeout_d, wd_hit;
  logic            unused_instr;

  assign unused_instr = ^instr[8:6];
  assign wd_hit       = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    op_d        = opcode;
    off_d       = offset;
    rd_d        = rd_addr;
    pc_sel_d    = pc_sel;
    wd_d        = wd_q;
    no_retire_d = no_retire_q;
    illegal_d   = 1'b0;
    timeout_d   = timeout_err;
    case (state_q)
      IDLE: begin
        if (instr_valid && instr_ready) begin
          op_d        = instr[15:12];
          rd_d        = instr[11:9];
          off_d       = instr[5:0];
          no_retire_d = 1'b0;
          state_d     = DECODE;
        end
      end
      DECODE: begin
        if (opcode >= 4'd13) begin
          illegal_d   = 1'b1;
          pc_sel_d    = 2'b00;
          no_retire_d = 1'b1;
          state_d     = RELEASE;
        end else if (!(isALUFinished || execute_branch || jump_flag)) begin
          // flags from the previous instruction must have been cleared first
          wd_d    = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        wd_d = wd_q + 1'b1;
        if (jump_flag) begin
          pc_sel_d = 2'b10;
          state_d  = RELEASE;
        end else if (execute_branch) begin
          pc_sel_d = 2'b01;
          state_d  = RELEASE;
        end else if (isALUFinished) begin
          if (opcode <= 4'd1) begin
            wd_d    = '0;
            state_d = MEM;
          end else if (opcode <= 4'd9) begin
            state_d = WB;
          end else begin
            pc_sel_d = 2'b00;
            state_d  = RELEASE;
          end
        end else if (wd_hit) begin
          timeout_d   = 1'b1;
          pc_sel_d    = 2'b00;
          no_retire_d = 1'b1;
          state_d     = RELEASE;
        end
      end
      MEM: begin
        wd_d = wd_q + 1'b1;
        if (mem_done) begin
          if (opcode == 4'd0) begin
            state_d = WB;
          end else begin
            pc_sel_d = 2'b00;
            state_d  = RELEASE;
          end
        end else if (wd_hit) begin
          timeout_d   = 1'b1;
          pc_sel_d    = 2'b00;
          no_retire_d = 1'b1;
          state_d     = RELEASE;
        end
      end
      WB: begin
        pc_sel_d = 2'b00;
        state_d  = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      no_retire_q   <= 1'b0;
      instr_ready   <= 1'b0;
      opcode        <= '0;
      offset        <= '0;
      rd_addr       <= '0;
      isALUOP       <= 1'b0;
      isLoadStore   <= 1'b0;
      memRead       <= 1'b0;
      memWrite      <= 1'b0;
      reg_write     <= 1'b0;
      pc_sel        <= 2'b00;
      fetchNextInst <= 1'b0;
      busy          <= 1'b0;
      illegal_op    <= 1'b0;
      timeout_err   <= 1'b0;
      instr_count   <= '0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      no_retire_q   <= no_retire_d;
      instr_ready   <= (state_d == IDLE);
      opcode        <= op_d;
      offset        <= off_d;
      rd_addr       <= rd_d;
      isALUOP       <= (state_d == EXEC) && (op_d >= 4'd2) && (op_d <= 4'd12);
      isLoadStore   <= (state_d == EXEC) && (op_d <= 4'd1);
      memRead       <= (state_d == MEM) && (op_d == 4'd0);
      memWrite      <= (state_d == MEM) && (op_d == 4'd1);
      reg_write     <= (state_d == WB);
      pc_sel        <= pc_sel_d;
      fetchNextInst <= (state_d == RELEASE);
      busy          <= (state_d != IDLE);
      illegal_op    <= illegal_d;
      timeout_err   <= timeout_d;
      if (state_q == RELEASE && !no_retire_q)
        instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with hand-computed cycle-by-cycle expectations.
module tb_alu_exec_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [3:0]  opcode;
  logic [5:0]  offset;
  logic        isALUOP, isLoadStore;
  logic        isALUFinished = 1'b0, execute_branch = 1'b0, jump_flag = 1'b0;
  logic        memRead, memWrite;
  logic        mem_done = 1'b0;
  logic        reg_write;
  logic [2:0]  rd_addr;
  logic [1:0]  pc_sel;
  logic        fetchNextInst, busy, illegal_op, timeout_err;
  logic [15:0] instr_count;
  int checks = 0;
  int failures = 0;

  alu_exec_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .opcode(opcode), .offset(offset),
    .isALUOP(isALUOP), .isLoadStore(isLoadStore), .isALUFinished(isALUFinished),
    .execute_branch(execute_branch), .jump_flag(jump_flag), .memRead(memRead),
    .memWrite(memWrite), .mem_done(mem_done), .reg_write(reg_write),
    .rd_addr(rd_addr), .pc_sel(pc_sel), .fetchNextInst(fetchNextInst),
    .busy(busy), .illegal_op(illegal_op), .timeout_err(timeout_err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1, "bench stalled");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present an instruction and complete the handshake; returns just after the accepting edge.
  task automatic issue(input logic [15:0] word);
    int n = 0;
    instr_valid = 1'b1;
    instr = word;
    while (!instr_ready && n < 20) begin tick(); n++; end
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL issue_ready got=%0b exp=1", instr_ready); end
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (instr_ready !== 1'b0 || busy !== 1'b0 || fetchNextInst !== 1'b0) begin failures++; $display("FAIL reset_ctrl got rdy=%0b busy=%0b fetch=%0b exp=0", instr_ready, busy, fetchNextInst); end
    checks++; if (instr_count !== 16'd0 || timeout_err !== 1'b0 || pc_sel !== 2'b00) begin failures++; $display("FAIL reset_state got cnt=%0d to=%0b pc=%0b exp=0", instr_count, timeout_err, pc_sel); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_first_ready got=%0b exp=1", instr_ready); end
  endtask

  task automatic test_add();
    issue(16'h2A00);
    checks++; if (busy !== 1'b1 || instr_ready !== 1'b0 || isALUOP !== 1'b0) begin failures++; $display("FAIL add_decode got busy=%0b rdy=%0b alu=%0b exp=1,0,0", busy, instr_ready, isALUOP); end
    tick();
    checks++; if (isALUOP !== 1'b1 || isLoadStore !== 1'b0 || opcode !== 4'd2) begin failures++; $display("FAIL add_exec got alu=%0b ls=%0b op=%0d exp=1,0,2", isALUOP, isLoadStore, opcode); end
    isALUFinished = 1'b1;
    tick();
    checks++; if (isALUOP !== 1'b0 || reg_write !== 1'b1 || rd_addr !== 3'd5) begin failures++; $display("FAIL add_wb got alu=%0b wr=%0b rd=%0d exp=0,1,5", isALUOP, reg_write, rd_addr); end
    tick();
    checks++; if (reg_write !== 1'b0 || fetchNextInst !== 1'b1 || pc_sel !== 2'b00) begin failures++; $display("FAIL add_release got wr=%0b fetch=%0b pc=%0b exp=0,1,00", reg_write, fetchNextInst, pc_sel); end
    isALUFinished = 1'b0;
    tick();
    checks++; if (fetchNextInst !== 1'b0 || instr_ready !== 1'b1 || instr_count !== 16'd1) begin failures++; $display("FAIL add_done got fetch=%0b rdy=%0b cnt=%0d exp=0,1,1", fetchNextInst, instr_ready, instr_count); end
  endtask

  task automatic test_load();
    issue(16'h0C05);
    tick();
    checks++; if (isLoadStore !== 1'b1 || isALUOP !== 1'b0 || offset !== 6'd5) begin failures++; $display("FAIL load_exec got ls=%0b alu=%0b off=%0d exp=1,0,5", isLoadStore, isALUOP, offset); end
    isALUFinished = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (memRead !== 1'b1 || memWrite !== 1'b0 || isLoadStore !== 1'b0) begin failures++; $display("FAIL load_mem%0d got rd=%0b wr=%0b ls=%0b exp=1,0,0", i, memRead, memWrite, isLoadStore); end
    end
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    checks++; if (memRead !== 1'b0 || reg_write !== 1'b1 || rd_addr !== 3'd6) begin failures++; $display("FAIL load_wb got mrd=%0b wr=%0b rd=%0d exp=0,1,6", memRead, reg_write, rd_addr); end
    tick();
    isALUFinished = 1'b0;
    checks++; if (fetchNextInst !== 1'b1 || pc_sel !== 2'b00) begin failures++; $display("FAIL load_release got fetch=%0b pc=%0b exp=1,00", fetchNextInst, pc_sel); end
    tick();
    checks++; if (instr_count !== 16'd2) begin failures++; $display("FAIL load_count got=%0d exp=2", instr_count); end
  endtask

  task automatic test_branch_jump();
    issue(16'hA000);
    tick();
    checks++; if (isALUOP !== 1'b1) begin failures++; $display("FAIL beqz_exec got=%0b exp=1", isALUOP); end
    execute_branch = 1'b1; isALUFinished = 1'b1;
    tick();
    checks++; if (fetchNextInst !== 1'b1 || pc_sel !== 2'b01 || reg_write !== 1'b0 || isALUOP !== 1'b0) begin failures++; $display("FAIL beqz_release got fetch=%0b pc=%0b wr=%0b alu=%0b exp=1,01,0,0", fetchNextInst, pc_sel, reg_write, isALUOP); end
    execute_branch = 1'b0; isALUFinished = 1'b0;
    tick();
    checks++; if (instr_count !== 16'd3) begin failures++; $display("FAIL beqz_count got=%0d exp=3", instr_count); end
    issue(16'hC000);
    tick();
    jump_flag = 1'b1; execute_branch = 1'b1; isALUFinished = 1'b1;
    tick();
    checks++; if (fetchNextInst !== 1'b1 || pc_sel !== 2'b10) begin failures++; $display("FAIL jump_release got fetch=%0b pc=%0b exp=1,10", fetchNextInst, pc_sel); end
    jump_flag = 1'b0; execute_branch = 1'b0; isALUFinished = 1'b0;
    tick();
    checks++; if (instr_count !== 16'd4) begin failures++; $display("FAIL jump_count got=%0d exp=4", instr_count); end
  endtask

  task automatic test_decode_stall();
    isALUFinished = 1'b1;
    issue(16'h2200);
    tick(); tick();
    checks++; if (busy !== 1'b1 || isALUOP !== 1'b0) begin failures++; $display("FAIL stall_hold got busy=%0b alu=%0b exp=1,0", busy, isALUOP); end
    isALUFinished = 1'b0;
    tick();
    checks++; if (isALUOP !== 1'b1) begin failures++; $display("FAIL stall_exit got=%0b exp=1", isALUOP); end
    isALUFinished = 1'b1;
    tick(); tick();
    isALUFinished = 1'b0;
    tick();
    checks++; if (instr_count !== 16'd5 || instr_ready !== 1'b1) begin failures++; $display("FAIL stall_done got cnt=%0d rdy=%0b exp=5,1", instr_count, instr_ready); end
  endtask

  task automatic test_timeout();
    issue(16'h3000);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (isALUOP !== 1'b1 || timeout_err !== 1'b0) begin failures++; $display("FAIL to_wait%0d got alu=%0b to=%0b exp=1,0", i, isALUOP, timeout_err); end
    end
    tick();
    checks++; if (isALUOP !== 1'b0 || timeout_err !== 1'b1 || fetchNextInst !== 1'b1 || pc_sel !== 2'b00) begin failures++; $display("FAIL to_abort got alu=%0b to=%0b fetch=%0b pc=%0b exp=0,1,1,00", isALUOP, timeout_err, fetchNextInst, pc_sel); end
    tick(); tick();
    checks++; if (timeout_err !== 1'b1 || instr_count !== 16'd5) begin failures++; $display("FAIL to_sticky got to=%0b cnt=%0d exp=1,5", timeout_err, instr_count); end
  endtask

  task automatic test_illegal();
    issue(16'hE000);
    checks++; if (illegal_op !== 1'b0) begin failures++; $display("FAIL ill_early got=%0b exp=0", illegal_op); end
    tick();
    checks++; if (illegal_op !== 1'b1 || isALUOP !== 1'b0 || fetchNextInst !== 1'b1 || pc_sel !== 2'b00) begin failures++; $display("FAIL ill_release got ill=%0b alu=%0b fetch=%0b pc=%0b exp=1,0,1,00", illegal_op, isALUOP, fetchNextInst, pc_sel); end
    tick();
    checks++; if (illegal_op !== 1'b0 || instr_count !== 16'd5) begin failures++; $display("FAIL ill_after got ill=%0b cnt=%0d exp=0,5", illegal_op, instr_count); end
  endtask

  task automatic test_reset_mid_store();
    issue(16'h1000);
    tick();
    isALUFinished = 1'b1;
    tick();
    checks++; if (memWrite !== 1'b1 || memRead !== 1'b0) begin failures++; $display("FAIL st_mem got wr=%0b rd=%0b exp=1,0", memWrite, memRead); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (memWrite !== 1'b0 || busy !== 1'b0 || instr_ready !== 1'b0 || timeout_err !== 1'b0 || instr_count !== 16'd0) begin failures++; $display("FAIL async_reset got wr=%0b busy=%0b rdy=%0b to=%0b cnt=%0d exp=0", memWrite, busy, instr_ready, timeout_err, instr_count); end
    isALUFinished = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++; if (instr_ready !== 1'b1 || timeout_err !== 1'b0 || instr_count !== 16'd0) begin failures++; $display("FAIL post_reset got rdy=%0b to=%0b cnt=%0d exp=1,0,0", instr_ready, timeout_err, instr_count); end
  endtask

  task automatic test_back_to_back();
    instr_valid = 1'b1; instr = 16'h4200;
    tick();
    tick();
    isALUFinished = 1'b1;
    tick(); tick();
    isALUFinished = 1'b0;
    checks++; if (instr_ready !== 1'b0 || fetchNextInst !== 1'b1) begin failures++; $display("FAIL b2b_release got rdy=%0b fetch=%0b exp=0,1", instr_ready, fetchNextInst); end
    tick();
    checks++; if (instr_ready !== 1'b1 || busy !== 1'b0 || instr_count !== 16'd1) begin failures++; $display("FAIL b2b_idle got rdy=%0b busy=%0b cnt=%0d exp=1,0,1", instr_ready, busy, instr_count); end
    tick();
    instr_valid = 1'b0;
    checks++; if (busy !== 1'b1 || instr_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept got busy=%0b rdy=%0b exp=1,0", busy, instr_ready); end
    tick();
    isALUFinished = 1'b1;
    tick(); tick();
    isALUFinished = 1'b0;
    tick();
    checks++; if (instr_count !== 16'd2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", instr_count); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_branch_jump();
    test_decode_stall();
    test_timeout();
    test_illegal();
    test_reset_mid_store();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
